// File: rtl/pes_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pes_arb_pkg
//  Brief    : Shared sizes, FSM state encoding and helpers for the
//             8-requester grant arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package pes_arb_pkg;

    // Number of requesters and the width of a requester index.
    localparam int NREQ = 8;
    localparam int ID_W = 3;

    // Width of the hold counter. Sized for the largest legal MAX_HOLD (255).
    localparam int HOLD_W = 8;

    // Arbiter FSM states, explicitly 2 bits wide.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        COOL  = 2'd2
    } arb_state_e;

    // Convert a requester index into its one-hot grant vector.
    function automatic logic [NREQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
        logic [NREQ-1:0] one;
        one = {{(NREQ-1){1'b0}}, 1'b1};
        return one << id;
    endfunction

endpackage : pes_arb_pkg
`default_nettype wire

// File: rtl/pes_prio_pick.sv
`default_nettype none
// ============================================================================
//  Module   : pes_prio_pick
//  Brief    : Combinational rotated priority pick. Searches req downward
//             from a start index with wrap-around (start, start-1, ... 0,
//             NREQ-1, ... start+1). In fixed mode the start is forced to
//             the top index, giving plain highest-index-wins priority.
//  Revision : 1.0 - initial release
// ============================================================================
module pes_prio_pick
    import pes_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] start_id,
    input  logic            rr_mode,
    output logic [ID_W-1:0] id,
    output logic            found
);

    logic [ID_W-1:0] eff_start;
    logic [ID_W-1:0] cand;

    // Choose where the descending search begins.
    always_comb begin
        eff_start = rr_mode ? start_id : ID_W'(NREQ - 1);
    end

    // Walk the requesters downward from eff_start; first set bit wins.
    // Index arithmetic is modulo NREQ because ID_W bits wrap naturally.
    always_comb begin
        id    = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = eff_start - ID_W'(i);
            if (!found && req[cand]) begin
                id    = cand;
                found = 1'b1;
            end
        end
    end

endmodule : pes_prio_pick
`default_nettype wire

// File: rtl/pes_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : pes_req_arbiter
//  Brief    : 8-way request arbiter with fixed-priority or round-robin
//             selection, a bounded hold time (MAX_HOLD cycles) with a
//             timeout pulse on forced release, and a one-cycle cool-down
//             between grants. All outputs come straight from flops.
//  Revision : 1.0 - initial release
// ============================================================================
module pes_req_arbiter
    import pes_arb_pkg::*;
#(
    // Maximum GRANT cycles before forced release. Legal range 1..255.
    parameter int MAX_HOLD = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            rr_mode,
    input  logic [NREQ-1:0] req,
    input  logic            done,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            gnt_valid,
    output logic            timeout
);

    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    arb_state_e        state_q,     state_d;
    logic [HOLD_W-1:0] hold_q,      hold_d;
    logic [ID_W-1:0]   last_id_q,   last_id_d;
    logic [NREQ-1:0]   gnt_q,       gnt_d;
    logic [ID_W-1:0]   gnt_id_q,    gnt_id_d;
    logic              gnt_valid_q, gnt_valid_d;
    logic              timeout_q,   timeout_d;

    // ------------------------------------------------------------------
    // Arbitration and grant-release decode
    // ------------------------------------------------------------------
    logic [ID_W-1:0] rr_start;
    logic [ID_W-1:0] pick_id;
    logic            pick_found;
    logic            req_held;
    logic            hold_expired;
    logic            release_req;
    logic            grant_start;
    logic            grant_keep;
    logic            grant_exit;
    logic            grant_abort;

    // Round-robin search begins just below the most recently granted index.
    always_comb begin
        rr_start = last_id_q - ID_W'(1);
    end

    pes_prio_pick u_pick (
        .req      (req),
        .start_id (rr_start),
        .rr_mode  (rr_mode),
        .id       (pick_id),
        .found    (pick_found)
    );

    // Decode the events that drive both the state and the datapath, so the
    // two comb processes below can never disagree about a transition.
    always_comb begin
        req_held     = req[gnt_id_q];
        hold_expired = (hold_q == HOLD_LIMIT);
        release_req  = done || !req_held || hold_expired;
        grant_start  = (state_q == IDLE)  && en && pick_found;
        grant_abort  = (state_q == GRANT) && !en;
        grant_exit   = (state_q == GRANT) && en && release_req;
        grant_keep   = (state_q == GRANT) && en && !release_req;
    end

    // ------------------------------------------------------------------
    // FSM state register plus every other flop of the block
    // ------------------------------------------------------------------
    // Asynchronous reset drops any grant immediately and clears history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            last_id_q   <= '0;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            last_id_q   <= last_id_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    // IDLE -> GRANT on a winner; GRANT -> COOL on release, -> IDLE on
    // abort; COOL always returns to IDLE after one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_start) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (grant_abort) begin
                    state_d = IDLE;
                end else if (grant_exit) begin
                    state_d = COOL;
                end
            end
            COOL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM output / datapath next values
    // ------------------------------------------------------------------
    // Grant outputs default to zero so IDLE and COOL present no grant;
    // they are only loaded on a new win or held while the grant persists.
    always_comb begin
        gnt_d     = '0;
        gnt_id_d  = '0;
        hold_d    = '0;
        timeout_d = 1'b0;
        last_id_d = last_id_q;

        if (grant_start) begin
            // Hold counter starts at 1 for the first GRANT cycle.
            gnt_d    = id_to_onehot(pick_id);
            gnt_id_d = pick_id;
            hold_d   = HOLD_W'(1);
        end else if (grant_keep) begin
            gnt_d    = gnt_q;
            gnt_id_d = gnt_id_q;
            hold_d   = hold_q + HOLD_W'(1);
        end else if (grant_abort) begin
            // Abort records the winner for fairness but never times out.
            last_id_d = gnt_id_q;
        end else if (grant_exit) begin
            // A timeout is reported only when the hold limit alone forced
            // the release: a concurrent done or dropped request wins.
            last_id_d = gnt_id_q;
            timeout_d = hold_expired && !done && req_held;
        end

        gnt_valid_d = |gnt_d;
    end

    // ------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------
    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule : pes_req_arbiter
`default_nettype wire

// File: tb/tb_pes_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pes_req_arbiter
//  Brief    : Directed scoreboard bench for pes_req_arbiter (MAX_HOLD=4).
//             The driver queues each expected grant (start cycle, id,
//             length, timeout on release); a monitor closes every observed
//             grant and compares it against the head of the queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pes_req_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en;
    logic       rr_mode;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    pes_req_arbiter #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .rr_mode   (rr_mode),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int start;
        int id;
        int len;
        int to;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int start, input int id, input int len, input int to);
        exp_t e;
        e.start = start;
        e.id    = id;
        e.len   = len;
        e.to    = to;
        exp_q.push_back(e);
    endtask

    // Advance to 1 time unit after the rising edge that makes cyc == c.
    task automatic at(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: track each grant and score it when it ends
    // ------------------------------------------------------------------
    bit         in_g = 1'b0;
    int         m_start, m_len;
    logic [2:0] m_id;
    logic [7:0] m_gnt;
    bit         m_stable;
    bit         mon_on = 1'b0;

    always @(negedge clk) begin
        exp_t       e;
        logic [7:0] one;
        if (mon_on) begin
            if (gnt_valid === 1'b1) begin
                if (!in_g) begin
                    in_g     = 1'b1;
                    m_start  = cyc;
                    m_id     = gnt_id;
                    m_gnt    = gnt;
                    m_len    = 1;
                    m_stable = 1'b1;
                end else begin
                    m_len++;
                    if (gnt !== m_gnt || gnt_id !== m_id) m_stable = 1'b0;
                end
                chk("timeout_in_grant", 32'(timeout), 32'd0);
            end else if (in_g) begin
                in_g = 1'b0;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_grant: got id %0d at cycle %0d, required no grant", m_id, m_start);
                end else begin
                    e   = exp_q.pop_front();
                    one = 8'h01;
                    one = one << e.id;
                    chk("grant_start_cycle", 32'(m_start), 32'(e.start));
                    chk("grant_id",          32'(m_id),    32'(e.id));
                    chk("grant_onehot",      32'(m_gnt),   32'(one));
                    chk("grant_length",      32'(m_len),   32'(e.len));
                    chk("grant_stable",      32'(m_stable), 32'd1);
                    chk("release_timeout",   32'(timeout), 32'(e.to));
                end
            end else begin
                chk("timeout_quiet", 32'(timeout), 32'd0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    initial begin
        int b;
        en      = 1'b0;
        rr_mode = 1'b0;
        req     = 8'h00;
        done    = 1'b0;
        #1 rst_n = 1'b0;

        // Reset state.
        @(negedge clk);
        chk("reset_gnt",       32'(gnt),       32'd0);
        chk("reset_gnt_id",    32'(gnt_id),    32'd0);
        chk("reset_gnt_valid", 32'(gnt_valid), 32'd0);
        chk("reset_timeout",   32'(timeout),   32'd0);
        mon_on = 1'b1;
        #2 rst_n = 1'b1;

        // Enabled but nothing requested: outputs stay zero for 20 cycles.
        en = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("idle_gnt",       32'(gnt),       32'd0);
            chk("idle_gnt_id",    32'(gnt_id),    32'd0);
            chk("idle_gnt_valid", 32'(gnt_valid), 32'd0);
        end
        @(posedge clk);
        #1;

        // Fixed priority: 0xA4 picks index 7; done in 3rd cycle; re-grant 7.
        b = cyc;
        rr_mode = 1'b0;
        req     = 8'hA4;
        push(b + 1, 7, 3, 0);
        at(b + 3); done = 1'b1;
        at(b + 4); done = 1'b0;
        push(b + 6, 7, 2, 0);
        at(b + 7); req = 8'h00;
        at(b + 10);

        // Abort by en=0 mid-grant, then round-robin proves last_id updated.
        b = cyc;
        req = 8'h04;
        push(b + 1, 2, 2, 0);
        at(b + 2); en = 1'b0;
        at(b + 3); en = 1'b1; req = 8'h00;
        at(b + 4); rr_mode = 1'b1; req = 8'h0A;
        push(b + 5, 1, 2, 0);
        at(b + 6); req = 8'h00;
        at(b + 9); rr_mode = 1'b0;

        // Reset mid-grant: grant drops at once, last_id returns to 0.
        b = cyc;
        req = 8'h10;
        push(b + 1, 4, 1, 0);
        at(b + 2);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_gnt",       32'(gnt),       32'd0);
        chk("async_reset_gnt_valid", 32'(gnt_valid), 32'd0);
        chk("async_reset_gnt_id",    32'(gnt_id),    32'd0);
        req = 8'h00;
        at(b + 4); rst_n = 1'b1;
        at(b + 5);

        // Round robin from reset: 7,6,...,0,7 with done held every grant.
        b = cyc;
        rr_mode = 1'b1;
        req     = 8'hFF;
        done    = 1'b1;
        for (int k = 0; k < 9; k++) push(b + 1 + 3 * k, (7 - k) & 7, 1, 0);
        at(b + 26); req = 8'h00; done = 1'b0;
        at(b + 29); rr_mode = 1'b0;

        // Timeout: req[2] held, no done -> 4 cycles, timeout, re-grant.
        b = cyc;
        req = 8'h04;
        push(b + 1, 2, 4, 1);
        push(b + 7, 2, 2, 0);
        at(b + 8); req = 8'h00;
        at(b + 11);

        // done coincides with hold count 4: release without timeout.
        b = cyc;
        req = 8'h04;
        push(b + 1, 2, 4, 0);
        at(b + 4); done = 1'b1;
        at(b + 5); done = 1'b0; req = 8'h00;
        at(b + 8);

        repeat (3) @(negedge clk);
        chk("all_grants_seen", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_pes_req_arbiter
`default_nettype wire

// File: doc/pes_req_arbiter.md
PES_REQ_ARBITER -- requirements
Module: pes_req_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 15, is the maximum number of GRANT cycles before forced release; legal range is 1..255.
REQ-002 clk  input  1  is the single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  is the reset: asynchronous assert, active-low.
REQ-004 en  input  1  is the arbiter enable; low means no new grants and abort of any current grant.
REQ-005 rr_mode  input  1  selects fairness: 0 = fixed priority (index 7 highest), 1 = round-robin.
REQ-006 req  input  8  carries one request bit per requester.
REQ-007 done  input  1  is asserted by the granted requester to release the resource.
REQ-008 gnt  output  8  is the one-hot grant, registered.
REQ-009 gnt_id  output  3  is the binary index of the granted requester, registered.
REQ-010 gnt_valid  output  1  is high exactly when gnt is nonzero.
REQ-011 timeout  output  1  is a one-cycle pulse when a grant is force-released by MAX_HOLD.

Function
REQ-012 The FSM SHALL have states IDLE, GRANT and COOL.
REQ-013 In IDLE with en=1 and req!=0, the winner SHALL be latched into gnt/gnt_id at the next edge and the FSM SHALL enter GRANT; latency from req to gnt is 1 cycle.
REQ-014 With rr_mode=0, the winner SHALL be the highest set req index.
REQ-015 With rr_mode=1, the search SHALL start at last_id-1 and descend with wrap-around (…, 0, 7, …), ending at last_id itself; last_id is the most recently granted index.
REQ-016 In IDLE with en=0 or req=0, the FSM SHALL stay in IDLE with gnt=0, gnt_id=0 and gnt_valid=0; outputs SHALL never be high-impedance.
REQ-017 In GRANT, gnt/gnt_id SHALL be held constant regardless of other req changes.
REQ-018 A hold counter SHALL count GRANT cycles starting at 1 in the first GRANT cycle.
REQ-019 GRANT SHALL exit to COOL at the next edge on any of: done=1; req[gnt_id]=0; hold count=MAX_HOLD.
REQ-020 timeout SHALL pulse for the one cycle in COOL only when the exit was by hold count and done=0 and req[gnt_id]=1.
REQ-021 When done and MAX_HOLD coincide, done SHALL win and timeout SHALL stay 0.
REQ-022 In GRANT, en=0 SHALL force a transition to IDLE at the next edge with gnt cleared; timeout SHALL stay 0; last_id SHALL still update.
REQ-023 COOL SHALL last exactly 1 cycle with gnt=0, then go to IDLE, giving a minimum 1-cycle gap between grants.
REQ-024 last_id SHALL update to gnt_id on every GRANT exit; rr_mode changes SHALL take effect only at the next IDLE arbitration.
REQ-025 done asserted outside GRANT SHALL be ignored.

Reset
REQ-026 On rst_n=0, the block SHALL immediately set state=IDLE, gnt=0, gnt_id=0, gnt_valid=0, timeout=0, hold count=0 and last_id=0 (so the first round-robin search starts at 7).
REQ-027 Reset during GRANT SHALL drop gnt asynchronously with no timeout pulse.
REQ-028 First arbitration SHALL occur at the first rising edge after rst_n deasserts with en=1 and req!=0.

Structure
REQ-029 Package pes_arb_pkg SHALL hold NREQ=8, ID_W=3 and the state enum {IDLE, GRANT, COOL}.
REQ-030 Sub-module pes_prio_pick SHALL implement the combinational rotated priority pick; inputs are req, start index and rr_mode; outputs are id and found.
REQ-031 All outputs SHALL be driven from flops; no combinational path from req to gnt.

Verification
REQ-032 Fixed priority: rr_mode=0, req=8'b1010_0100, done after 3 cycles -> gnt=8'h80, gnt_id=7 one cycle later; COOL; then gnt=8'h80 again.
REQ-033 Round robin: rr_mode=1, req=8'hFF held, done every grant -> gnt_id sequence 7,6,5,…,0,7 with a 1-cycle gap between grants.
REQ-034 Timeout: MAX_HOLD=4, req[2] held, done=0 -> gnt_id=2 for 4 cycles, timeout=1 for 1 cycle, then re-grant of 2.
REQ-035 Simultaneous: done=1 on hold count 4 with MAX_HOLD=4 -> release with timeout=0.
REQ-036 Abort/reset: en=0 mid-GRANT -> gnt=0 next edge with no timeout; separately, rst_n=0 mid-GRANT -> gnt=0 immediately, last_id=0.
REQ-037 Idle: en=1, req=0 for 20 cycles -> gnt=0, gnt_id=0 and gnt_valid=0 throughout.
